// File: rtl/seg_scan_if.sv
// Display-side bundle for the seven-segment scan driver.
// The master (the display word source) drives the controls; the slave (scan driver) drives the digit outputs.
interface seg_scan_if #(
  parameter int N_DIGITS = 8
);
  logic                    load;
  logic [4*N_DIGITS-1:0]   din;
  logic [N_DIGITS-1:0]     digit_en;
  logic                    blank_lz;
  logic [3:0]              x;
  logic [N_DIGITS-1:0]     an;
  logic                    frame_done;

  modport master (
    output load, din, digit_en, blank_lz,
    input  x, an, frame_done
  );

  modport slave (
    input  load, din, digit_en, blank_lz,
    output x, an, frame_done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan controller for an N-digit seven-segment display.
// Display words are committed only at the frame wrap, so a frame never mixes old and new data.
//
// state | meaning
// S_ON  | digit idx lit for REFRESH_DIV cycles
// S_GAP | all anodes off for GAP_CYC cycles, x already holds the next digit
module seg_scan_driver #(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int GAP_CYC     = 16
) (
  input  logic clk,
  input  logic reset_n,
  seg_scan_if.slave bus
);
  localparam int DW      = 4 * N_DIGITS;
  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_MAX = (REFRESH_DIV > GAP_CYC) ? REFRESH_DIV : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;

  localparam logic [0:0] S_ON  = 1'b0;
  localparam logic [0:0] S_GAP = 1'b1;

  logic [DW-1:0]       shadow_q, shadow_d;
  logic [DW-1:0]       pend_q, pend_d;
  logic                pend_v_q, pend_v_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [0:0]          state_q, state_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [3:0]          x_q, x_d;
  logic                frame_done_q, frame_done_d;

  logic                wrap;
  logic [IDX_W-1:0]    hi_idx;
  logic [3:0]          nib_sel;
  logic                en_sel;
  logic                dark;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wrap    = 1'b0;
    case (state_q)
      S_ON: begin
        if (cnt_q == ON_LAST) begin
          cnt_d = '0;
          idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          wrap  = (idx_q == IDX_LAST);
          if (GAP_CYC > 0) state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_ON;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // A load landing on the wrap bypasses pend so the newest word wins.
  always_comb begin
    shadow_d = shadow_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if (wrap) begin
      if (bus.load) begin
        shadow_d = bus.din;
        pend_v_d = 1'b0;
      end else if (pend_v_q) begin
        shadow_d = pend_q;
        pend_v_d = 1'b0;
      end
    end else if (bus.load) begin
      pend_d   = bus.din;
      pend_v_d = 1'b1;
    end
  end

  // Highest nonzero nibble; stays 0 for an all-zero word so digit 0 always shows.
  always_comb begin
    hi_idx = '0;
    for (int i = 1; i < N_DIGITS; i++) begin
      if (shadow_q[4*i +: 4] != 4'h0) hi_idx = IDX_W'(i);
    end
  end

  always_comb begin
    nib_sel = 4'h0;
    en_sel  = 1'b0;
    an_d    = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_sel = shadow_q[4*i +: 4];
        en_sel  = bus.digit_en[i];
      end
    end
    dark = !en_sel || (bus.blank_lz && (idx_q > hi_idx));
    x_d  = dark ? 4'hF : nib_sel;
    if ((state_q == S_ON) && !dark) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (idx_q == IDX_W'(i)) an_d[i] = 1'b0;
      end
    end
    frame_done_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_q     <= '0;
      pend_q       <= '0;
      pend_v_q     <= 1'b0;
      idx_q        <= '0;
      cnt_q        <= '0;
      state_q      <= S_ON;
      an_q         <= '1;
      x_q          <= 4'h0;
      frame_done_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      an_q         <= an_d;
      x_q          <= x_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.x          = x_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with REFRESH_DIV=4, GAP_CYC=1, N_DIGITS=8.
// Output tick t (t-th edge after reset release) is checked against a per-slot expectation.
module tb_seg_scan_driver;
  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  int   t;

  seg_scan_if #(.N_DIGITS(8)) bus ();

  seg_scan_driver #(
    .N_DIGITS(8),
    .REFRESH_DIV(4),
    .GAP_CYC(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_reset(input string tag);
    @(posedge clk);
    #2;
    total++;
    assert (bus.an === 8'hFF) else begin
      bad++;
      $error("FAIL %s_an observed=%h expected=ff", tag, bus.an);
    end
    total++;
    assert (bus.x === 4'h0) else begin
      bad++;
      $error("FAIL %s_x observed=%h expected=0", tag, bus.x);
    end
    total++;
    assert (bus.frame_done === 1'b0) else begin
      bad++;
      $error("FAIL %s_fd observed=%b expected=0", tag, bus.frame_done);
    end
  endtask

  // Each digit slot is 5 ticks: 4 lit, then 1 gap showing the next digit's nibble.
  task automatic run_ticks(input int n, input logic [31:0] shw, input logic [7:0] en,
                           input logic blz, input string tag);
    int p, d, ph, dd, hi;
    logic lit, dark, exp_fd;
    logic [3:0] exp_x;
    logic [7:0] exp_an;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
      t++;
      p  = t - 1;
      d  = (p / 5) % 8;
      ph = p % 5;
      if (ph == 4) begin
        dd  = (d + 1) % 8;
        lit = 1'b0;
      end else begin
        dd  = d;
        lit = 1'b1;
      end
      hi = 0;
      for (int i = 1; i < 8; i++) if (shw[4*i +: 4] != 4'h0) hi = i;
      dark   = !en[dd] || (blz && (dd > hi));
      exp_x  = dark ? 4'hF : shw[4*dd +: 4];
      exp_an = (lit && !dark) ? ~(8'b1 << dd) : 8'hFF;
      exp_fd = ((t % 40) == 39);
      total++;
      assert (bus.an === exp_an) else begin
        bad++;
        $error("FAIL %s_an t=%0d observed=%h expected=%h", tag, t, bus.an, exp_an);
      end
      total++;
      assert (bus.x === exp_x) else begin
        bad++;
        $error("FAIL %s_x t=%0d observed=%h expected=%h", tag, t, bus.x, exp_x);
      end
      total++;
      assert (bus.frame_done === exp_fd) else begin
        bad++;
        $error("FAIL %s_fd t=%0d observed=%b expected=%b", tag, t, bus.frame_done, exp_fd);
      end
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    t            = 0;
    reset_n      = 1'b0;
    bus.load     = 1'b0;
    bus.din      = '0;
    bus.digit_en = 8'hFF;
    bus.blank_lz = 1'b0;
    repeat (2) @(posedge clk);
    chk_reset("reset");

    // Frame 0 still shows the reset word; the load waits for the wrap.
    reset_n  = 1'b1;
    bus.load = 1'b1;
    bus.din  = 32'h76543210;
    run_ticks(1, 32'h0, 8'hFF, 1'b0, "f0");
    bus.load = 1'b0;
    run_ticks(38, 32'h0, 8'hFF, 1'b0, "f0");

    // Frame 1: load arrives while digit 3 is lit and must not show yet.
    run_ticks(16, 32'h76543210, 8'hFF, 1'b0, "f1");
    bus.load = 1'b1;
    bus.din  = 32'h00000099;
    run_ticks(1, 32'h76543210, 8'hFF, 1'b0, "f1");
    bus.load = 1'b0;
    run_ticks(23, 32'h76543210, 8'hFF, 1'b0, "f1");

    run_ticks(6, 32'h00000099, 8'hFF, 1'b0, "f2");
    bus.load = 1'b1;
    bus.din  = 32'h0;
    run_ticks(1, 32'h00000099, 8'hFF, 1'b0, "f2");
    bus.load = 1'b0;
    run_ticks(33, 32'h00000099, 8'hFF, 1'b0, "f2");

    bus.blank_lz = 1'b1;
    run_ticks(6, 32'h0, 8'hFF, 1'b1, "lz0");
    bus.load = 1'b1;
    bus.din  = 32'h00012000;
    run_ticks(1, 32'h0, 8'hFF, 1'b1, "lz0");
    bus.load = 1'b0;
    run_ticks(33, 32'h0, 8'hFF, 1'b1, "lz0");

    // Two loads near the wrap: the one on the wrap cycle itself must win.
    run_ticks(37, 32'h00012000, 8'hFF, 1'b1, "lz1");
    bus.load = 1'b1;
    bus.din  = 32'h11111111;
    run_ticks(1, 32'h00012000, 8'hFF, 1'b1, "lz1");
    bus.load = 1'b0;
    run_ticks(1, 32'h00012000, 8'hFF, 1'b1, "lz1");
    bus.load = 1'b1;
    bus.din  = 32'hAAAAAAAA;
    run_ticks(1, 32'h00012000, 8'hFF, 1'b1, "lz1");
    bus.load = 1'b0;

    bus.blank_lz = 1'b0;
    bus.digit_en = 8'b1010_1010;
    run_ticks(40, 32'hAAAAAAAA, 8'b1010_1010, 1'b0, "en");

    // Leave a pending word, then reset during the gap before digit 5.
    bus.digit_en = 8'hFF;
    run_ticks(6, 32'hAAAAAAAA, 8'hFF, 1'b0, "f6");
    bus.load = 1'b1;
    bus.din  = 32'h55555555;
    run_ticks(1, 32'hAAAAAAAA, 8'hFF, 1'b0, "f6");
    bus.load = 1'b0;
    run_ticks(18, 32'hAAAAAAAA, 8'hFF, 1'b0, "f6");
    reset_n = 1'b0;
    chk_reset("rst_gap");

    reset_n = 1'b1;
    t       = 0;
    run_ticks(80, 32'h0, 8'hFF, 1'b0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
